alu_operand_select: RTL and testbench

// - Execute-stage operand/function selector for the Y86-64 pipeline: from E_icode/E_ifun and
//   the E-register values, produces ALU inputs aluA, aluB, the 2-bit alufun, and set_cc.
// - Sits between the EXECUTE register outputs and the 64-bit ALU block. Merges the former
//   A-select, B-select and function-select logic.
// - Optional output register (REG_OUT) for timing; this needs clk and rst_n.

---
 rtl/y86_pkg.sv | 24 ++
 rtl/alu_out_reg.sv | 15 +
 rtl/alu_operand_select.sv | 81 ++++++++
 tb/tb_alu_operand_select.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the execute-stage operand selector.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    // Signed so a size cast to any datapath width sign-extends correctly.
    localparam logic signed [63:0] C_PLUS8  = 64'sd8;
    localparam logic signed [63:0] C_MINUS8 = -64'sd8;
endpackage

// File: rtl/alu_out_reg.sv
// Enabled output register with asynchronous active-low clear.
module alu_out_reg #(
    parameter int DW = 131
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/alu_operand_select.sv
// Execute-stage ALU operand and function selection, optionally registered.
module alu_operand_select
    import y86_pkg::*;
#(
    parameter int W       = 64,
    parameter bit REG_OUT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [W-1:0] E_valC,
    output logic [W-1:0] aluA,
    output logic [W-1:0] aluB,
    output logic [1:0]   alufun,
    output logic         set_cc
);
    localparam int DW = 2*W + 3;

    logic [W-1:0] a_sel, b_sel;
    logic [1:0]   fun_sel;
    logic         cc_sel;
    logic         unused_ifun;

    assign unused_ifun = ^E_ifun[3:2];

    always_comb begin
        a_sel = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:             a_sel = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: a_sel = E_valC;
            I_CALL, I_PUSHQ:             a_sel = W'(C_MINUS8);
            I_RET, I_POPQ:               a_sel = W'(C_PLUS8);
            default:                     a_sel = '0;
        endcase
    end

    always_comb begin
        b_sel = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ,
            I_CALL, I_PUSHQ, I_RET, I_POPQ: b_sel = E_valB;
            default:                        b_sel = '0;
        endcase
    end

    always_comb begin
        fun_sel = ALU_ADD;
        case (E_icode)
            I_OPQ:   fun_sel = E_ifun[1:0];
            default: fun_sel = ALU_ADD;
        endcase
    end

    always_comb begin
        cc_sel = 1'b0;
        case (E_icode)
            I_OPQ:   cc_sel = 1'b1;
            default: cc_sel = 1'b0;
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg
            alu_out_reg #(.DW(DW)) u_out_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .d     ({a_sel, b_sel, fun_sel, cc_sel}),
                .q     ({aluA, aluB, alufun, set_cc})
            );
        end else begin : g_comb
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst_n, en};
            assign {aluA, aluB, alufun, set_cc} = {a_sel, b_sel, fun_sel, cc_sel};
        end
    endgenerate
endmodule

// File: tb/tb_alu_operand_select.sv
// Bench for alu_operand_select: combinational and registered instances against a reference model.
module tb_alu_operand_select;
    localparam int W  = 64;
    localparam int DW = 2*W + 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [3:0]   E_icode = 4'h1;
    logic [3:0]   E_ifun = 4'h0;
    logic [W-1:0] E_valA = '0, E_valB = '0, E_valC = '0;

    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   f0, f1;
    logic         c0, c1;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q = '0;

    always #5 clk = ~clk;

    alu_operand_select #(.W(W), .REG_OUT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .aluA(a0), .aluB(b0), .alufun(f0), .set_cc(c0)
    );

    alu_operand_select #(.W(W), .REG_OUT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .aluA(a1), .aluB(b1), .alufun(f1), .set_cc(c1)
    );

    wire [DW-1:0] obs0 = {a0, b0, f0, c0};
    wire [DW-1:0] obs1 = {a1, b1, f1, c1};

    // Reference: which operand each instruction class feeds to the ALU.
    function automatic logic [DW-1:0] model(input logic [3:0] ic, input logic [3:0] fn,
                                            input logic [W-1:0] va, vb, vc);
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic [1:0]   f = 2'd0;
        logic         c = 1'b0;
        if (ic == 4'd2 || ic == 4'd6)       a = va;
        else if (ic inside {4'd3, 4'd4, 4'd5}) a = vc;
        else if (ic == 4'd8 || ic == 4'd10) a = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (ic == 4'd9 || ic == 4'd11) a = 64'd8;
        if (ic inside {4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11}) b = vb;
        if (ic == 4'd6) begin
            f = fn[1:0];
            c = 1'b1;
        end
        return {a, b, f, c};
    endfunction

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [W-1:0] va, vb, vc);
        E_icode = ic; E_ifun = fn; E_valA = va; E_valB = vb; E_valC = vc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        drive(4'd6, 4'd1, 64'd5, 64'd12, 64'd3);
        #2;
        total++;
        if (obs1 !== '0) begin bad++; $display("FAIL reset_async got=%h want=0", obs1); end
        total++;
        if (obs0 !== model(4'd6, 4'd1, 64'd5, 64'd12, 64'd3)) begin
            bad++; $display("FAIL reset_comb_unaffected got=%h", obs0);
        end
        @(posedge clk); #1;
        total++;
        if (obs1 !== '0) begin bad++; $display("FAIL reset_wins_over_en got=%h want=0", obs1); end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q = '0;
    endtask

    task automatic test_directed();
        drive(4'd6, 4'd1, 64'd5, 64'd12, 64'd0); #1;
        total++;
        if (obs0 !== {64'd5, 64'd12, 2'd1, 1'b1}) begin bad++; $display("FAIL opq_sub got=%h", obs0); end
        drive(4'd5, 4'd0, 64'd7, 64'h20, 64'h100); #1;
        total++;
        if (obs0 !== {64'h100, 64'h20, 2'd0, 1'b0}) begin bad++; $display("FAIL mrmovq got=%h", obs0); end
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ics [4] = '{4'hA, 4'h8, 4'hB, 4'h9};
            logic [W-1:0] want_a;
            want_a = (i < 2) ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'd8;
            drive(ics[i], 4'h3, 64'h55, 64'h200, 64'h77); #1;
            total++;
            if (obs0 !== {want_a, 64'h200, 2'd0, 1'b0}) begin
                bad++; $display("FAIL stack_icode_%h got=%h", ics[i], obs0);
            end
        end
        drive(4'd2, 4'd0, 64'd9, 64'd77, 64'd66); #1;
        total++;
        if (obs0 !== {64'd9, 64'd0, 2'd0, 1'b0}) begin bad++; $display("FAIL rrmovq got=%h", obs0); end
        drive(4'd3, 4'd0, 64'd11, 64'd77, 64'd42); #1;
        total++;
        if (obs0 !== {64'd42, 64'd0, 2'd0, 1'b0}) begin bad++; $display("FAIL irmovq got=%h", obs0); end
        for (int i = 0; i < 4; i++) begin
            logic [3:0] zs [4] = '{4'h1, 4'h0, 4'h7, 4'hF};
            drive(zs[i], 4'hF, 64'h1234, 64'h5678, 64'h9ABC); #1;
            total++;
            if (obs0 !== '0) begin bad++; $display("FAIL zero_icode_%h got=%h want=0", zs[i], obs0); end
        end
        drive(4'd6, 4'hE, 64'd1, 64'd2, 64'd3); #1;
        total++;
        if (obs0 !== {64'd1, 64'd2, 2'd2, 1'b1}) begin bad++; $display("FAIL ifun_high_ignored got=%h", obs0); end
    endtask

    task automatic test_reg_seq();
        @(posedge clk); #1;
        en = 1'b1;
        drive(4'd6, 4'd3, 64'hF0F0, 64'h0FF0, 64'd0);
        #2;
        total++;
        if (obs1 !== exp_q) begin bad++; $display("FAIL reg_before_edge got=%h want=%h", obs1, exp_q); end
        @(posedge clk); #1;
        exp_q = model(4'd6, 4'd3, 64'hF0F0, 64'h0FF0, 64'd0);
        total++;
        if (obs1 !== exp_q) begin bad++; $display("FAIL reg_load got=%h want=%h", obs1, exp_q); end
        en = 1'b0;
        drive(4'd5, 4'd0, 64'd1, 64'd2, 64'd3);
        @(posedge clk); #1;
        total++;
        if (obs1 !== exp_q) begin bad++; $display("FAIL reg_hold got=%h want=%h", obs1, exp_q); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs1 !== '0) begin bad++; $display("FAIL reg_midcycle_reset got=%h want=0", obs1); end
        #1 rst_n = 1'b1;
        exp_q = '0;
        @(posedge clk); #1;
        total++;
        if (obs1 !== '0) begin bad++; $display("FAIL reg_clear_persists got=%h want=0", obs1); end
        en = 1'b1;
        @(posedge clk); #1;
        exp_q = model(4'd5, 4'd0, 64'd1, 64'd2, 64'd3);
        total++;
        if (obs1 !== exp_q) begin bad++; $display("FAIL reg_reload got=%h want=%h", obs1, exp_q); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            logic [3:0] ic, fn;
            logic [W-1:0] va, vb, vc;
            ic = 4'($urandom_range(0, 15));
            fn = 4'($urandom_range(0, 15));
            va = {$urandom, $urandom};
            vb = {$urandom, $urandom};
            vc = {$urandom, $urandom};
            drive(ic, fn, va, vb, vc);
            en = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (obs0 !== model(ic, fn, va, vb, vc)) begin
                bad++; $display("FAIL rand_comb n=%0d icode=%h got=%h want=%h", n, ic, obs0, model(ic, fn, va, vb, vc));
            end
            @(posedge clk);
            if (en) exp_q = model(ic, fn, va, vb, vc);
            #1;
            total++;
            if (obs1 !== exp_q) begin
                bad++; $display("FAIL rand_reg n=%0d en=%0b got=%h want=%h", n, en, obs1, exp_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reg_seq();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
